g_item_bank: RTL and testbench

Parametrised bank of N collectible power-up items (mushrooms, flowers) sharing one character hitbox.
- Each item has its own lifecycle: hidden, emerging from a block, collectable, taken.
- Detects character/item overlap with a proper bounding-box test and emits one-cycle pickup pulses.
- Keeps a saturating collect counter and produces scrolled screen coordinates for the renderer.
- Sits between the game-state logic (character position, block-hit spawn requests, frame tick) and the VGA sprite mux.

---
 rtl/g_item_bank.sv | 202 ++++++++++++++++++++
 tb/tb_g_item_bank.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/g_item_bank.sv
// g_item_bank: a bank of N_ITEMS collectible power-up items sharing one
// character hitbox. Each item runs its own HIDDEN/EMERGE/ACTIVE/TAKEN
// lifecycle. Pickups produce registered one-cycle pulses and feed a
// saturating collect counter. Screen coordinates are produced for the
// sprite mux.
// Optional feature macro: ITEM_RESPAWN_EN. When it is defined, a taken
// item re-hides after RESPAWN_TICKS frame ticks. When it is undefined,
// no timers are built and TAKEN is terminal.
module g_item_bank #(
  parameter int                 N_ITEMS       = 4,
  parameter int                 W             = 10,
  parameter int                 ITEM_SZ       = 12,
  parameter int                 CHAR_SZ       = 12,
  parameter int                 EMERGE_H      = 12,
  parameter int                 CNT_W         = 8,
  parameter logic [N_ITEMS-1:0] INIT_ACTIVE   = {N_ITEMS{1'b0}},
  parameter int                 RESPAWN_TICKS = 255
) (
  input  logic                   sys_clk,
  input  logic                   RST_N,
  input  logic                   tick,
  input  logic [W-1:0]           char_x,
  input  logic [W-1:0]           char_y,
  input  logic [W-1:0]           bg_pos,
  input  logic [N_ITEMS*W-1:0]   item_x_flat,
  input  logic [N_ITEMS*W-1:0]   item_y_flat,
  input  logic [N_ITEMS-1:0]     spawn_req,
  output logic [N_ITEMS*W-1:0]   scr_x_flat,
  output logic [N_ITEMS*W-1:0]   scr_y_flat,
  output logic [N_ITEMS-1:0]     visible,
  output logic [N_ITEMS-1:0]     touch_pulse,
  output logic                   any_touch,
  output logic [CNT_W-1:0]       collect_count
);

  localparam int PC_W  = $clog2(N_ITEMS + 1);
  localparam int SUM_W = CNT_W + PC_W;
  localparam logic [SUM_W-1:0] CNT_MAX = {{PC_W{1'b0}}, {CNT_W{1'b1}}};
`ifdef ITEM_RESPAWN_EN
  // Timer counts 0..RESPAWN_TICKS-1; the tick that would reach RESPAWN_TICKS re-hides the item.
  localparam int TMR_W = (RESPAWN_TICKS > 1) ? $clog2(RESPAWN_TICKS) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(RESPAWN_TICKS - 1);
`endif

  typedef enum logic [1:0] {
    ST_HIDDEN = 2'd0,
    ST_EMERGE = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_TAKEN  = 2'd3
  } item_state_e;

  function automatic logic [PC_W-1:0] popcount(input logic [N_ITEMS-1:0] v);
    logic [PC_W-1:0] acc;
    acc = {PC_W{1'b0}};
    for (int k = 0; k < N_ITEMS; k++) begin
      acc = acc + PC_W'(v[k]);
    end
    return acc;
  endfunction

  logic [N_ITEMS-1:0] hit_nxt_s;
  logic [N_ITEMS-1:0] vis_s;
  logic [SUM_W-1:0]   cnt_sum_s;
  logic [CNT_W-1:0]   cnt_nxt_s;

  for (genvar i = 0; i < N_ITEMS; i++) begin : g_item
    item_state_e  state_r, state_nxt_s;
    logic [W-1:0] off_r, off_nxt_s;
    logic [W-1:0] ix_s, iy_s;
    logic [W:0]   cx0_s, cx1_s, cy0_s, cy1_s, ix0_s, ix1_s, iy0_s, iy1_s;
    logic         ovl_s;
    logic         hit_s;
`ifdef ITEM_RESPAWN_EN
    logic [TMR_W-1:0] tmr_r, tmr_nxt_s;
`endif

    assign ix_s = item_x_flat[i*W +: W];
    assign iy_s = item_y_flat[i*W +: W];

    // Edges are widened by one bit so the far edge never wraps at the top of the range.
    assign cx0_s = {1'b0, char_x};
    assign cy0_s = {1'b0, char_y};
    assign ix0_s = {1'b0, ix_s};
    assign iy0_s = {1'b0, iy_s};
    assign cx1_s = cx0_s + (W+1)'(CHAR_SZ);
    assign cy1_s = cy0_s + (W+1)'(CHAR_SZ);
    assign ix1_s = ix0_s + (W+1)'(ITEM_SZ);
    assign iy1_s = iy0_s + (W+1)'(ITEM_SZ);
    assign ovl_s = (cx0_s < ix1_s) && (cx1_s > ix0_s) && (cy0_s < iy1_s) && (cy1_s > iy0_s);

    // Item lifecycle state, emerge offset and respawn timer.
    always_ff @(posedge sys_clk or negedge RST_N) begin
      if (!RST_N) begin
        state_r <= INIT_ACTIVE[i] ? ST_ACTIVE : ST_HIDDEN;
        off_r   <= {W{1'b0}};
`ifdef ITEM_RESPAWN_EN
        tmr_r   <= {TMR_W{1'b0}};
`endif
      end else begin
        state_r <= state_nxt_s;
        off_r   <= off_nxt_s;
`ifdef ITEM_RESPAWN_EN
        tmr_r   <= tmr_nxt_s;
`endif
      end
    end

    // Next-state logic: spawn, emerge motion, pickup and optional respawn.
    always_comb begin
      state_nxt_s = state_r;
      off_nxt_s   = off_r;
      hit_s       = 1'b0;
`ifdef ITEM_RESPAWN_EN
      tmr_nxt_s   = tmr_r;
`endif
      case (state_r)
        ST_HIDDEN: begin
          if (spawn_req[i]) begin
            state_nxt_s = ST_EMERGE;
            off_nxt_s   = W'(EMERGE_H);
          end else begin
            state_nxt_s = ST_HIDDEN;
          end
        end
        ST_EMERGE: begin
          if (tick) begin
            if (off_r <= W'(1)) begin
              state_nxt_s = ST_ACTIVE;
              off_nxt_s   = {W{1'b0}};
            end else begin
              off_nxt_s   = off_r - W'(1);
            end
          end else begin
            off_nxt_s = off_r;
          end
        end
        ST_ACTIVE: begin
          if (ovl_s) begin
            state_nxt_s = ST_TAKEN;
            hit_s       = 1'b1;
`ifdef ITEM_RESPAWN_EN
            tmr_nxt_s   = {TMR_W{1'b0}};
`endif
          end else begin
            state_nxt_s = ST_ACTIVE;
          end
        end
        ST_TAKEN: begin
`ifdef ITEM_RESPAWN_EN
          if (tick) begin
            if (tmr_r == TMR_LAST) begin
              state_nxt_s = ST_HIDDEN;
              tmr_nxt_s   = {TMR_W{1'b0}};
            end else begin
              tmr_nxt_s   = tmr_r + TMR_W'(1);
            end
          end else begin
            tmr_nxt_s = tmr_r;
          end
`else
          state_nxt_s = ST_TAKEN;
`endif
        end
        default: begin
          state_nxt_s = ST_HIDDEN;
          off_nxt_s   = {W{1'b0}};
        end
      endcase
    end

    assign hit_nxt_s[i]            = hit_s;
    assign vis_s[i]                = (state_r == ST_EMERGE) || (state_r == ST_ACTIVE);
    assign scr_x_flat[i*W +: W]    = ix_s - bg_pos;
    assign scr_y_flat[i*W +: W]    = iy_s + off_r;
  end

  assign visible = vis_s;

  // Saturating add of all pickups registered this cycle.
  always_comb begin
    cnt_sum_s = SUM_W'(collect_count) + SUM_W'(popcount(hit_nxt_s));
    if (cnt_sum_s > CNT_MAX) begin
      cnt_nxt_s = {CNT_W{1'b1}};
    end else begin
      cnt_nxt_s = cnt_sum_s[CNT_W-1:0];
    end
  end

  // Registered pickup pulses and collect counter.
  always_ff @(posedge sys_clk or negedge RST_N) begin
    if (!RST_N) begin
      touch_pulse   <= {N_ITEMS{1'b0}};
      any_touch     <= 1'b0;
      collect_count <= {CNT_W{1'b0}};
    end else begin
      touch_pulse   <= hit_nxt_s;
      any_touch     <= |hit_nxt_s;
      collect_count <= cnt_nxt_s;
    end
  end

endmodule

// File: tb/tb_g_item_bank.sv
// Directed testbench for g_item_bank with a scoreboard queue of expectations.
// Two instances: dut_a (INIT_ACTIVE=0001, 8-bit counter) for lifecycle and
// overlap checks, dut_b (all items active, 2-bit counter) for saturation.
module tb_g_item_bank;

  localparam int N = 4;
  localparam int W = 10;

  logic           sys_clk = 1'b0;
  logic           RST_N;
  logic           tick;
  logic [W-1:0]   char_x, char_y, b_char_x, b_char_y, bg_pos;
  logic [N*W-1:0] item_x_flat, item_y_flat;
  logic [N-1:0]   spawn_req, b_spawn;

  logic [N*W-1:0] a_scr_x, a_scr_y, b_scr_x, b_scr_y;
  logic [N-1:0]   a_vis, a_touch, b_vis, b_touch;
  logic           a_any, b_any;
  logic [7:0]     a_cnt;
  logic [1:0]     b_cnt;

  g_item_bank #(.N_ITEMS(N), .W(W), .CNT_W(8), .INIT_ACTIVE(4'b0001), .RESPAWN_TICKS(3)) dut_a (
    .sys_clk(sys_clk), .RST_N(RST_N), .tick(tick), .char_x(char_x), .char_y(char_y),
    .bg_pos(bg_pos), .item_x_flat(item_x_flat), .item_y_flat(item_y_flat),
    .spawn_req(spawn_req), .scr_x_flat(a_scr_x), .scr_y_flat(a_scr_y), .visible(a_vis),
    .touch_pulse(a_touch), .any_touch(a_any), .collect_count(a_cnt));

  g_item_bank #(.N_ITEMS(N), .W(W), .CNT_W(2), .INIT_ACTIVE(4'b1111), .RESPAWN_TICKS(255)) dut_b (
    .sys_clk(sys_clk), .RST_N(RST_N), .tick(tick), .char_x(b_char_x), .char_y(b_char_y),
    .bg_pos(bg_pos), .item_x_flat(item_x_flat), .item_y_flat(item_y_flat),
    .spawn_req(b_spawn), .scr_x_flat(b_scr_x), .scr_y_flat(b_scr_y), .visible(b_vis),
    .touch_pulse(b_touch), .any_touch(b_any), .collect_count(b_cnt));

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb_q.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $error("FAIL scoreboard_empty: observed %0d with no expectation queued", obs);
    end else begin
      e = sb_q.pop_front();
      n_chk++;
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic cyc();
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  task automatic tick_pair();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    cyc();
  endtask

  function automatic logic [31:0] fld(input logic [N*W-1:0] f, input int i);
    return 32'(f[i*W +: W]);
  endfunction

  task automatic park();
    char_x = 10'd900;
    char_y = 10'd900;
  endtask

  int bx[4] = '{305, 100, 40, 65};
  int by[4] = '{115, 80, 40, 65};
  int bc[4] = '{1, 2, 3, 3};

  initial begin
    RST_N = 1'b0; tick = 1'b0; bg_pos = 10'd0;
    spawn_req = 4'b0000; b_spawn = 4'b0000;
    park();
    b_char_x = 10'd900; b_char_y = 10'd900;
    item_x_flat = {10'd55, 10'd50, 10'd100, 10'd305};
    item_y_flat = {10'd55, 10'd50, 10'd80, 10'd115};
    #12;
    push("rst_vis", 32'd1); push("rst_cnt", 32'd0); push("rst_touch", 32'd0);
    push("rst_any", 32'd0); push("rst_b_vis", 32'd15); push("rst_scr_y0", 32'd115);
    chk(a_vis); chk(a_cnt); chk(a_touch); chk(a_any); chk(b_vis); chk(fld(a_scr_y, 0));
    @(negedge sys_clk);
    RST_N = 1'b1;

    // Scrolled screen X wraps modulo 2^W.
    bg_pos = 10'd310;
    #1;
    push("scr_x0_wrap", 32'd1019); push("scr_x1_wrap", 32'd814);
    chk(fld(a_scr_x, 0)); chk(fld(a_scr_x, 1));
    bg_pos = 10'd0;
    #1;
    push("scr_x3", 32'd55);
    chk(fld(a_scr_x, 3));

    // Saturating counter on dut_b: four single pickups.
    for (int i = 0; i < 4; i++) begin
      b_char_x = W'(bx[i]);
      b_char_y = W'(by[i]);
      push("b_touch", 32'd1 << i);
      push("b_cnt_sat", 32'(bc[i]));
      cyc();
      chk(b_touch); chk(b_cnt);
    end
    b_char_x = 10'd900; b_char_y = 10'd900;

    // Item1 emerge; spawn on already-active item0 is ignored.
    spawn_req = 4'b0011;
    push("spawn_vis", 32'd3); push("spawn_y1", 32'd92);
    cyc();
    chk(a_vis); chk(fld(a_scr_y, 1));
    spawn_req = 4'b0000;
    char_x = 10'd100; char_y = 10'd80;
    for (int k = 1; k <= 12; k++) begin
      tick = 1'b1;
      push("emerge_y1", 32'(92 - k)); push("emerge_touch", 32'd0); push("emerge_vis", 32'd3);
      cyc();
      chk(fld(a_scr_y, 1)); chk(a_touch); chk(a_vis);
      tick = 1'b0;
      if (k < 12) push("emerge_idle_touch", 32'd0);
      else        push("first_active_touch", 32'd2);
      cyc();
      chk(a_touch);
    end
    push("pickup1_cnt", 32'd1);
    chk(a_cnt);
    park();
    push("after1_touch", 32'd0); push("after1_vis", 32'd1);
    cyc();
    chk(a_touch); chk(a_vis);

    // Item0 at (305,115): touching edge, then real overlap, then hold.
    char_x = 10'd293; char_y = 10'd115;
    push("edge_touch", 32'd0);
    cyc();
    chk(a_touch);
    char_x = 10'd294;
    push("ovl_touch", 32'd1); push("ovl_any", 32'd1); push("ovl_cnt", 32'd2);
    cyc();
    chk(a_touch); chk(a_any); chk(a_cnt);
    push("hold_touch", 32'd0); push("hold_any", 32'd0); push("hold_cnt", 32'd2); push("hold_vis", 32'd0);
    cyc();
    chk(a_touch); chk(a_any); chk(a_cnt); chk(a_vis);
    push("hold2_touch", 32'd0);
    cyc();
    chk(a_touch);
    park();

    // Items 2 and 3 taken in the same cycle.
    spawn_req = 4'b1100;
    push("spawn23_vis", 32'd12);
    cyc();
    chk(a_vis);
    spawn_req = 4'b0000;
    for (int k = 0; k < 12; k++) tick_pair();
    push("emerged_y2", 32'd50); push("emerged_vis", 32'd12);
    chk(fld(a_scr_y, 2)); chk(a_vis);
    char_x = 10'd52; char_y = 10'd52;
    push("dual_touch", 32'd12); push("dual_any", 32'd1); push("dual_cnt", 32'd4);
    cyc();
    chk(a_touch); chk(a_any); chk(a_cnt);
    push("dual_after_touch", 32'd0); push("dual_after_any", 32'd0);
    push("dual_after_cnt", 32'd4); push("dual_after_vis", 32'd0);
    cyc();
    chk(a_touch); chk(a_any); chk(a_cnt); chk(a_vis);
    park();

`ifdef ITEM_RESPAWN_EN
    // Item0 respawned to HIDDEN earlier; re-emerge, pick up, count down.
    spawn_req = 4'b0001;
    push("respawn_vis", 32'd1);
    cyc();
    chk(a_vis);
    spawn_req = 4'b0000;
    for (int k = 0; k < 12; k++) tick_pair();
    push("re_y0", 32'd115);
    chk(fld(a_scr_y, 0));
    char_x = 10'd300; char_y = 10'd115;
    push("re_touch", 32'd1); push("re_cnt", 32'd5);
    cyc();
    chk(a_touch); chk(a_cnt);
    park();
    spawn_req = 4'b0001;
    tick = 1'b1; push("taken_t1_vis", 32'd0); cyc(); chk(a_vis); tick = 1'b0;
    for (int k = 0; k < 3; k++) begin
      push("taken_notick_vis", 32'd0); cyc(); chk(a_vis);
    end
    tick = 1'b1; push("taken_t2_vis", 32'd0); cyc(); chk(a_vis); tick = 1'b0;
    push("taken_t2_idle_vis", 32'd0); cyc(); chk(a_vis);
    tick = 1'b1; push("taken_t3_vis", 32'd0); cyc(); chk(a_vis); tick = 1'b0;
    push("rehide_spawn_vis", 32'd1); push("rehide_spawn_y0", 32'd127);
    cyc();
    chk(a_vis); chk(fld(a_scr_y, 0));
    spawn_req = 4'b0000;
    for (int k = 0; k < 12; k++) tick_pair();
    char_x = 10'd300; char_y = 10'd115;
    push("re2_touch", 32'd1); push("re2_cnt", 32'd6);
    cyc();
    chk(a_touch); chk(a_cnt);
    park();
    tick_pair();
    RST_N = 1'b0;
    #1;
    push("midrespawn_vis", 32'd1); push("midrespawn_cnt", 32'd0); push("midrespawn_touch", 32'd0);
    chk(a_vis); chk(a_cnt); chk(a_touch);
    @(negedge sys_clk);
    RST_N = 1'b1;
`else
    // Without respawn, a taken item ignores further spawn requests.
    for (int k = 0; k < 4; k++) tick_pair();
    spawn_req = 4'b0001;
    push("terminal_vis", 32'd0);
    cyc();
    chk(a_vis);
    spawn_req = 4'b0000;
    push("terminal_cnt", 32'd4);
    chk(a_cnt);
`endif

    // Reset in the middle of an emerge.
    RST_N = 1'b0;
    @(negedge sys_clk);
    RST_N = 1'b1;
    spawn_req = 4'b0010;
    push("final_spawn_y1", 32'd92);
    cyc();
    chk(fld(a_scr_y, 1));
    spawn_req = 4'b0000;
    for (int k = 0; k < 3; k++) tick_pair();
    push("final_mid_y1", 32'd89); push("final_mid_vis", 32'd3);
    chk(fld(a_scr_y, 1)); chk(a_vis);
    RST_N = 1'b0;
    #1;
    push("midemerge_vis", 32'd1); push("midemerge_y1", 32'd80); push("midemerge_cnt", 32'd0);
    chk(a_vis); chk(fld(a_scr_y, 1)); chk(a_cnt);
    @(negedge sys_clk);
    RST_N = 1'b1;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
